// File: rtl/apb_timer_slave.sv
// apb_timer_slave: APB completer for the timer slot. Decodes APB setup and
// access phases, exposes five word registers (LOAD, VALUE, CTRL, INTCLR, RIS),
// runs a prescaled down-counter with one-shot/periodic modes and drives a
// registered level interrupt.
//
// Bus handshake: there is no PREADY, so a transfer is always one setup cycle
// (PSEL=1, PENABLE=0) followed by one access cycle (PSEL=1, PENABLE=1).
// Read data is captured at the edge ending setup and held for the access
// cycle; a write commits at the edge ending access. The FSM register lags the
// bus phase by one edge: it reads SETUP while the bus is in its access cycle.
module apb_timer_slave #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  HCLK,
  input  logic                  HRESET,
  input  logic                  PSEL,
  input  logic                  PENABLE,
  input  logic                  PWRITE,
  input  logic [ADDR_WIDTH-1:0] PADDR,
  input  logic [DATA_WIDTH-1:0] PWDATA,
  output logic [DATA_WIDTH-1:0] PRDATA,
  output logic                  TIMINT,
  output logic [1:0]            apb_state
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] SETUP  = 2'd1;
  localparam logic [1:0] ACCESS = 2'd2;

  localparam logic [DATA_WIDTH-1:0] ONE = {{(DATA_WIDTH-1){1'b0}}, 1'b1};

  logic [1:0]            state;
  logic [1:0]            state_next;
  logic                  setup_cyc;
  logic                  commit;
  logic [2:0]            reg_idx;
  logic                  wr_load;
  logic                  wr_ctrl;
  logic                  wr_clr;

  logic [DATA_WIDTH-1:0] load_q;
  logic [DATA_WIDTH-1:0] value_q;
  logic                  en_q;
  logic                  per_q;
  logic                  inten_q;
  logic [1:0]            presc_q;
  logic                  ris_q;
  logic [7:0]            pcnt;
  logic [7:0]            div_m1;
  logic                  tick;
  logic                  underflow;
  logic [DATA_WIDTH-1:0] rdata;
  logic                  unused_addr;

  assign reg_idx     = PADDR[4:2];
  assign unused_addr = ^{PADDR[ADDR_WIDTH-1:5], PADDR[1:0]};
  assign setup_cyc   = PSEL & ~PENABLE;
  // A commit needs the FSM to have seen the setup cycle, so a transfer that
  // is already in its access phase when reset releases never writes.
  assign commit      = (state == SETUP) & PSEL & PENABLE & PWRITE;
  assign wr_load     = commit & (reg_idx == 3'd0);
  assign wr_ctrl     = commit & (reg_idx == 3'd2);
  assign wr_clr      = commit & (reg_idx == 3'd3);
  assign apb_state   = state;

  // Next-state decode for the APB phase tracker
  always_comb begin
    state_next = IDLE;
    case (state)
      IDLE:    state_next = setup_cyc ? SETUP : IDLE;
      SETUP: begin
        if (PSEL & PENABLE) state_next = ACCESS;
        else if (setup_cyc) state_next = SETUP;
        else                state_next = IDLE;
      end
      ACCESS:  state_next = setup_cyc ? SETUP : IDLE;
      default: state_next = IDLE;
    endcase
  end

  // APB phase tracker register
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) state <= IDLE;
    else        state <= state_next;
  end

  // Prescaler terminal count: /1, /16, /256 (both upper codes are /256)
  always_comb begin
    div_m1 = 8'd255;
    case (presc_q)
      2'd0:    div_m1 = 8'd0;
      2'd1:    div_m1 = 8'd15;
      default: div_m1 = 8'd255;
    endcase
  end

  assign tick      = en_q & (pcnt == div_m1);
  assign underflow = tick & (value_q == '0);

  // Prescaler: restarts from 0 whenever disabled, reprogrammed or reloaded
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET)                                 pcnt <= 8'd0;
    else if (!en_q || wr_ctrl || wr_load || tick) pcnt <= 8'd0;
    else                                        pcnt <= pcnt + 8'd1;
  end

  // LOAD register and the down-counter; a LOAD write overrides a same-cycle tick
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      load_q  <= '0;
      value_q <= '0;
    end else begin
      if (wr_load) begin
        load_q  <= PWDATA;
        value_q <= PWDATA;
      end else if (tick) begin
        if (value_q != '0) value_q <= value_q - ONE;
        else if (per_q)    value_q <= load_q;
        else               value_q <= '0;
      end
    end
  end

  // CTRL fields; a one-shot underflow self-clears EN unless CTRL is written
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      en_q    <= 1'b0;
      per_q   <= 1'b0;
      inten_q <= 1'b0;
      presc_q <= 2'd0;
    end else if (wr_ctrl) begin
      en_q    <= PWDATA[0];
      per_q   <= PWDATA[1];
      inten_q <= PWDATA[2];
      presc_q <= PWDATA[5:4];
    end else if (underflow && !per_q) begin
      en_q    <= 1'b0;
    end
  end

  // Raw interrupt status: a same-cycle set beats an INTCLR write
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET)         ris_q <= 1'b0;
    else if (underflow) ris_q <= 1'b1;
    else if (wr_clr)    ris_q <= 1'b0;
  end

  // Registered interrupt output, one cycle behind RIS/INTEN
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) TIMINT <= 1'b0;
    else        TIMINT <= ris_q & inten_q;
  end

  // Read mux over the register map; unmapped offsets and INTCLR read 0
  always_comb begin
    rdata = '0;
    case (reg_idx)
      3'd0:    rdata = load_q;
      3'd1:    rdata = value_q;
      3'd2:    rdata = {{(DATA_WIDTH-6){1'b0}}, presc_q, 1'b0, inten_q, per_q, en_q};
      3'd4:    rdata = {{(DATA_WIDTH-1){1'b0}}, ris_q};
      default: rdata = '0;
    endcase
  end

  // Read data captured at the end of setup, zero in every other cycle
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET)                 PRDATA <= '0;
    else if (setup_cyc & ~PWRITE) PRDATA <= rdata;
    else                        PRDATA <= '0;
  end

endmodule

// File: tb/tb_apb_timer_slave.sv
// tb_apb_timer_slave: register table, timed probe table, hand-written corner
// sequences, and a randomized run checked against an arithmetic timer model.
module tb_apb_timer_slave;

  localparam logic [31:0] A_LOAD  = 32'h00;
  localparam logic [31:0] A_VALUE = 32'h04;
  localparam logic [31:0] A_CTRL  = 32'h08;
  localparam logic [31:0] A_CLR   = 32'h0C;
  localparam logic [31:0] A_RIS   = 32'h10;

  logic        HCLK = 1'b0;
  logic        HRESET = 1'b1;
  logic        PSEL = 1'b0;
  logic        PENABLE = 1'b0;
  logic        PWRITE = 1'b0;
  logic [31:0] PADDR = 32'h0;
  logic [31:0] PWDATA = 32'h0;
  logic [31:0] PRDATA;
  logic        TIMINT;
  logic [1:0]  apb_state;

  longint cyc = 0;
  int     checks = 0;
  int     failures = 0;

  apb_timer_slave #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) dut (
    .HCLK(HCLK), .HRESET(HRESET), .PSEL(PSEL), .PENABLE(PENABLE),
    .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(PRDATA),
    .TIMINT(TIMINT), .apb_state(apb_state)
  );

  // ---------------- clock / reset / cycle index ----------------
  always #5 HCLK = ~HCLK;
  always @(posedge HCLK) cyc <= cyc + 1;

  // ---------------- scoreboard ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- driver tasks (inputs change 1ns after the edge) ----------------
  task automatic step();
    @(posedge HCLK);
    #1;
  endtask

  task automatic idle();
    PSEL = 1'b0;
    PENABLE = 1'b0;
    step();
  endtask

  task automatic idle_to(input longint target);
    while (cyc < target) idle();
  endtask

  // Returns just after the commit edge, bus left in access so a following
  // transfer can start back-to-back.
  task automatic apb_write(input logic [31:0] addr, input logic [31:0] data);
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = addr; PWDATA = data;
    step();
    PENABLE = 1'b1;
    step();
  endtask

  // c_setup is the cycle whose register contents the read captures.
  task automatic apb_read(input logic [31:0] addr, output logic [31:0] data,
                          output logic tim, output longint c_setup);
    logic [31:0] junk;
    junk = $urandom();
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = addr; PWDATA = junk;
    c_setup = cyc;
    step();
    PENABLE = 1'b1;
    data = PRDATA;
    tim = TIMINT;
    step();
    check("prdata_after_access", PRDATA, 32'h0);
  endtask

  task automatic read_check(input string name, input logic [31:0] addr, input logic [31:0] exp);
    logic [31:0] d;
    logic        t;
    longint      c;
    apb_read(addr, d, t, c);
    check(name, d, exp);
  endtask

  // ---------------- reference model ----------------
  // The timer is described by an epoch: the state right after the last
  // LOAD/CTRL write (which also restarts the prescaler). Any later cycle is
  // derived arithmetically from the number of ticks elapsed since then.
  longint     m_c0, m_v0, m_load, m_ris_ref;
  bit         m_en, m_per, m_inten, m_ris_flag;
  logic [1:0] m_presc;

  function automatic longint m_div();
    case (m_presc)
      2'd0:    return 1;
      2'd1:    return 16;
      default: return 256;
    endcase
  endfunction

  function automatic longint m_ticks(input longint c);
    if (!m_en) return 0;
    return (c - m_c0) / m_div();
  endfunction

  // Number of times RIS has been set within the epoch up to cycle c.
  function automatic longint m_nsets(input longint c);
    longint k;
    k = m_ticks(c);
    if (k <= m_v0) return 0;
    if (!m_per)    return 1;
    return 1 + (k - m_v0 - 1) / (m_load + 1);
  endfunction

  function automatic longint m_value(input longint c);
    longint k;
    k = m_ticks(c);
    if (k <= m_v0) return m_v0 - k;
    if (!m_per)    return 0;
    return m_load - ((k - m_v0 - 1) % (m_load + 1));
  endfunction

  function automatic bit m_en_at(input longint c);
    return m_en && !(!m_per && m_ticks(c) > m_v0);
  endfunction

  function automatic bit m_ris(input longint c);
    return m_ris_flag || (m_nsets(c) > m_nsets(m_ris_ref));
  endfunction

  function automatic logic [31:0] m_read(input logic [31:0] addr, input longint c);
    logic [31:0] r;
    r = 32'h0;
    case (addr[4:2])
      3'd0: r = 32'(m_load);
      3'd1: r = 32'(m_value(c));
      3'd2: begin
        r[0]   = m_en_at(c);
        r[1]   = m_per;
        r[2]   = m_inten;
        r[5:4] = m_presc;
      end
      3'd4: r[0] = m_ris(c);
      default: r = 32'h0;
    endcase
    return r;
  endfunction

  task automatic m_reset(input longint c);
    m_c0 = c; m_v0 = 0; m_load = 0; m_en = 0; m_per = 0; m_inten = 0;
    m_presc = 2'd0; m_ris_flag = 0; m_ris_ref = c;
  endtask

  task automatic m_write(input longint c, input logic [31:0] addr, input logic [31:0] data);
    bit     r, e;
    longint v;
    case (addr[4:2])
      3'd0: begin
        e = m_en_at(c); r = m_ris(c);
        m_load = longint'(data); m_v0 = longint'(data); m_en = e;
        m_c0 = c; m_ris_flag = r; m_ris_ref = c;
      end
      3'd2: begin
        v = m_value(c); r = m_ris(c);
        m_v0 = v; m_en = data[0]; m_per = data[1]; m_inten = data[2];
        m_presc = data[5:4]; m_c0 = c; m_ris_flag = r; m_ris_ref = c;
      end
      3'd3: begin
        m_ris_flag = m_nsets(c) > m_nsets(c - 1);
        m_ris_ref = c;
      end
      default: ;
    endcase
  endtask

  // ---------------- stimulus tables ----------------
  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [31:0] data;
    logic [31:0] exp;
  } reg_vec_t;

  typedef struct {
    logic [31:0] load;
    logic [31:0] ctrl;
    int          clr_d;
    int          d;
    logic [31:0] addr;
    logic [31:0] exp;
  } probe_t;

  reg_vec_t rv [0:17];
  probe_t   pv [0:24];

  // ---------------- watchdog ----------------
  initial begin
    #2000000;
    failures++;
    $display("FAIL watchdog actual=timeout required=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // ---------------- main test ----------------
  initial begin
    logic [31:0] d, a, w, tmp;
    logic        t;
    longint      c, x;
    int          op, gap;

    rv[0]  = '{1'b1, A_LOAD,  32'h5,         32'h0};
    rv[1]  = '{1'b0, A_VALUE, 32'h0,         32'h5};
    rv[2]  = '{1'b0, A_LOAD,  32'h0,         32'h5};
    rv[3]  = '{1'b0, 32'h14,  32'h0,         32'h0};
    rv[4]  = '{1'b1, A_CTRL,  32'hFFFF_FFE8, 32'h0};
    rv[5]  = '{1'b0, A_CTRL,  32'h0,         32'h20};
    rv[6]  = '{1'b1, 32'h14,  32'hDEAD,      32'h0};
    rv[7]  = '{1'b0, 32'h14,  32'h0,         32'h0};
    rv[8]  = '{1'b0, 32'h1C,  32'h0,         32'h0};
    rv[9]  = '{1'b1, A_VALUE, 32'h77,        32'h0};
    rv[10] = '{1'b0, A_VALUE, 32'h0,         32'h5};
    rv[11] = '{1'b1, A_RIS,   32'h1,         32'h0};
    rv[12] = '{1'b0, A_RIS,   32'h0,         32'h0};
    rv[13] = '{1'b0, A_CLR,   32'h0,         32'h0};
    rv[14] = '{1'b1, A_LOAD,  32'hFFFF_FFFF, 32'h0};
    rv[15] = '{1'b0, A_VALUE, 32'h0,         32'hFFFF_FFFF};
    rv[16] = '{1'b1, A_CTRL,  32'h0,         32'h0};
    rv[17] = '{1'b0, A_CTRL,  32'h0,         32'h0};

    // one-shot /1, LOAD=3
    pv[0]  = '{32'd3, 32'h05, 0, 0,   A_VALUE, 32'd3};
    pv[1]  = '{32'd3, 32'h05, 0, 1,   A_VALUE, 32'd2};
    pv[2]  = '{32'd3, 32'h05, 0, 2,   A_VALUE, 32'd1};
    pv[3]  = '{32'd3, 32'h05, 0, 3,   A_VALUE, 32'd0};
    pv[4]  = '{32'd3, 32'h05, 0, 3,   A_RIS,   32'd0};
    pv[5]  = '{32'd3, 32'h05, 0, 4,   A_RIS,   32'd1};
    pv[6]  = '{32'd3, 32'h05, 0, 6,   A_CTRL,  32'h4};
    pv[7]  = '{32'd3, 32'h05, 0, 10,  A_VALUE, 32'd0};
    // periodic /16, LOAD=2
    pv[8]  = '{32'd2, 32'h17, 0, 15,  A_VALUE, 32'd2};
    pv[9]  = '{32'd2, 32'h17, 0, 16,  A_VALUE, 32'd1};
    pv[10] = '{32'd2, 32'h17, 0, 32,  A_VALUE, 32'd0};
    pv[11] = '{32'd2, 32'h17, 0, 47,  A_RIS,   32'd0};
    pv[12] = '{32'd2, 32'h17, 0, 48,  A_RIS,   32'd1};
    pv[13] = '{32'd2, 32'h17, 0, 48,  A_VALUE, 32'd2};
    pv[14] = '{32'd2, 32'h17, 0, 95,  A_VALUE, 32'd0};
    pv[15] = '{32'd2, 32'h17, 50, 95, A_RIS,   32'd0};
    pv[16] = '{32'd2, 32'h17, 50, 96, A_RIS,   32'd1};
    // LOAD=0 periodic /1: set on every tick beats INTCLR
    pv[17] = '{32'd0, 32'h07, 5, 7,   A_RIS,   32'd1};
    // /256 one-shot and periodic, both upper prescale codes
    pv[18] = '{32'd1, 32'h21, 0, 255, A_VALUE, 32'd1};
    pv[19] = '{32'd1, 32'h21, 0, 256, A_VALUE, 32'd0};
    pv[20] = '{32'd1, 32'h21, 0, 511, A_RIS,   32'd0};
    pv[21] = '{32'd1, 32'h21, 0, 512, A_RIS,   32'd1};
    pv[22] = '{32'd1, 32'h31, 0, 256, A_VALUE, 32'd0};
    pv[23] = '{32'd1, 32'h33, 0, 600, A_VALUE, 32'd1};
    pv[24] = '{32'd1, 32'h33, 0, 768, A_VALUE, 32'd0};

    // Reset defaults
    step(); step();
    check("reset_prdata", PRDATA, 32'h0);
    check("reset_timint", {31'h0, TIMINT}, 32'h0);
    check("reset_state", {30'h0, apb_state}, 32'h0);
    HRESET = 1'b0;
    step();

    // Register table, applied back-to-back
    for (int i = 0; i < 18; i++) begin
      if (rv[i].wr) apb_write(rv[i].addr, rv[i].data);
      else          read_check($sformatf("regvec%0d", i), rv[i].addr, rv[i].exp);
    end
    idle();
    check("prdata_idle", PRDATA, 32'h0);

    // Timed probes: restart the timer, then read one register at a fixed offset
    for (int i = 0; i < 25; i++) begin
      apb_write(A_CTRL, 32'h0);
      apb_write(A_CLR, 32'h0);
      apb_write(A_LOAD, pv[i].load);
      apb_write(A_CTRL, pv[i].ctrl);
      x = cyc;
      if (pv[i].clr_d > 0) begin
        idle_to(x + longint'(pv[i].clr_d));
        apb_write(A_CLR, 32'h0);
      end
      idle_to(x + longint'(pv[i].d));
      read_check($sformatf("probe%0d", i), pv[i].addr, pv[i].exp);
    end

    // One-shot interrupt timing and clear
    apb_write(A_CTRL, 32'h0);
    apb_write(A_CLR, 32'h0);
    apb_write(A_LOAD, 32'd3);
    apb_write(A_CTRL, 32'h5);
    x = cyc;
    idle_to(x + 4);
    check("timint_before", {31'h0, TIMINT}, 32'h0);
    idle();
    check("timint_set", {31'h0, TIMINT}, 32'h1);
    apb_write(A_CLR, 32'h0);
    check("timint_clr_latency", {31'h0, TIMINT}, 32'h1);
    idle();
    check("timint_cleared", {31'h0, TIMINT}, 32'h0);

    // Simultaneous set/clear, then stop and clear
    apb_write(A_LOAD, 32'h0);
    apb_write(A_CTRL, 32'h7);
    idle(); idle(); idle();
    apb_write(A_CLR, 32'h0);
    read_check("ris_set_wins", A_RIS, 32'h1);
    apb_write(A_CTRL, 32'h0);
    apb_write(A_CLR, 32'h0);
    read_check("ris_stopped_clear", A_RIS, 32'h0);

    // Aborted transfer: setup only, then PSEL drops
    apb_write(A_LOAD, 32'h1111);
    check("access_state", {30'h0, apb_state}, 32'h2);
    idle();
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = A_LOAD; PWDATA = 32'hDEAD;
    step();
    check("abort_setup_state", {30'h0, apb_state}, 32'h1);
    PSEL = 1'b0;
    step();
    check("abort_idle_state", {30'h0, apb_state}, 32'h0);
    read_check("abort_load", A_LOAD, 32'h1111);

    // Reset in the middle of a write, with the interrupt asserted
    apb_write(A_LOAD, 32'h0);
    apb_write(A_CTRL, 32'h5);
    idle(); idle(); idle();
    check("pre_reset_timint", {31'h0, TIMINT}, 32'h1);
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = A_LOAD; PWDATA = 32'h1234;
    step();
    PENABLE = 1'b1;
    #2;
    HRESET = 1'b1;
    #1;
    check("async_reset_prdata", PRDATA, 32'h0);
    check("async_reset_timint", {31'h0, TIMINT}, 32'h0);
    check("async_reset_state", {30'h0, apb_state}, 32'h0);
    @(posedge HCLK);
    @(posedge HCLK);
    #1;
    HRESET = 1'b0;
    step();
    check("held_access_state", {30'h0, apb_state}, 32'h0);
    idle();
    read_check("rst_load", A_LOAD, 32'h0);
    read_check("rst_value", A_VALUE, 32'h0);
    read_check("rst_ctrl", A_CTRL, 32'h0);
    read_check("rst_clr", A_CLR, 32'h0);
    read_check("rst_ris", A_RIS, 32'h0);
    check("rst_timint", {31'h0, TIMINT}, 32'h0);

    // Randomized traffic against the model
    HRESET = 1'b1;
    step(); step();
    HRESET = 1'b0;
    m_reset(cyc);
    step();
    for (int n = 0; n < 250; n++) begin
      op = $urandom_range(0, 9);
      tmp = $urandom();
      a = {tmp[31:5], 5'h0};
      a[1:0] = tmp[1:0];
      w = $urandom();
      if (op <= 1) begin
        a[4:2] = 3'd0;
        if ($urandom_range(0, 7) != 0) w = 32'($urandom_range(0, 6));
        apb_write(a, w);
        m_write(cyc, a, w);
      end else if (op <= 3) begin
        a[4:2] = 3'd2;
        apb_write(a, w);
        m_write(cyc, a, w);
      end else if (op == 4) begin
        a[4:2] = 3'd3;
        apb_write(a, w);
        m_write(cyc, a, w);
      end else if (op == 5) begin
        case ($urandom_range(0, 4))
          0: a[4:2] = 3'd1;
          1: a[4:2] = 3'd4;
          2: a[4:2] = 3'd5;
          3: a[4:2] = 3'd6;
          default: a[4:2] = 3'd7;
        endcase
        apb_write(a, w);
        m_write(cyc, a, w);
      end else begin
        a[4:2] = 3'($urandom_range(0, 7));
        apb_read(a, d, t, c);
        check($sformatf("rand_read%0d_off%0h", n, a[4:0] & 5'h1C), d, m_read(a, c));
        check($sformatf("rand_timint%0d", n), {31'h0, t}, {31'h0, m_ris(c) & m_inten});
      end
      gap = $urandom_range(0, 3);
      for (int g = 0; g < gap; g++) idle();
    end

    idle();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
